stream_select_arbiter: RTL and testbench

Packet-granular round-robin scheduler that drives the `select` stream of the stream data multiplexer. It watches the per-input `valid` of the `NUM_STREAMS` competing `ndata_i` streams and issues one stream index per packet on a `ready_valid_i` master port. It holds that index until the multiplexer retires the packet by handshaking `select` on the output `last` beat. An optional burst allowance lets a stream keep the grant for up to `MAX_BURST` back-to-back packets.

---
 rtl/stream_select_arbiter.sv | 111 +++++++++++
 tb/tb_stream_select_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_select_arbiter.sv
// Packet-granular round-robin scheduler for the stream multiplexer's select stream.
// One stream index is issued per packet, with an optional burst allowance per stream.
module stream_select_arbiter #(
    parameter int NUM_STREAMS = 4,
    parameter int MAX_BURST   = 1,
    parameter int IDX_W       = $clog2(NUM_STREAMS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_STREAMS-1:0] req,
    input  logic [NUM_STREAMS-1:0] enable,
    output logic                   select_valid,
    input  logic                   select_ready,
    output logic [IDX_W-1:0]       select_data,
    output logic                   busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic [IDX_W-1:0]     cur;
    logic [IDX_W-1:0]     cur_nxt;
    logic [CNT_W-1:0]     burst_cnt;
    logic [CNT_W-1:0]     burst_cnt_nxt;
    logic [NUM_STREAMS-1:0] elig;
    logic [IDX_W-1:0]     winner;
    logic                 win_found;
    logic [IDX_W-1:0]     cur_inc;
    logic                 keep_burst;

    assign elig = req & enable;

    // Scan from ptr upward with wrap; the first eligible stream wins.
    always_comb begin
        int idx;
        winner    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_STREAMS) begin
                idx = idx - NUM_STREAMS;
            end
            if (!win_found && elig[IDX_W'(idx)]) begin
                winner    = IDX_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign cur_inc    = (cur == IDX_W'(NUM_STREAMS - 1)) ? '0 : cur + 1'b1;
    assign keep_burst = ((int'(burst_cnt) + 1) < MAX_BURST) && elig[cur];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cur       <= cur_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cur_nxt       = cur;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    cur_nxt       = winner;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                // The grant is only ever released by a handshake, never revoked.
                if (select_ready) begin
                    if (keep_burst) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end else begin
                        ptr_nxt       = cur_inc;
                        burst_cnt_nxt = '0;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign select_valid = (state == GRANT);
    assign select_data  = cur;
    assign busy         = select_valid;

endmodule

// File: tb/tb_stream_select_arbiter.sv
// Bench for stream_select_arbiter: two instances (burst 1 and burst 3) driven in
// lockstep and compared every cycle against a packet-level round-robin model.
module tb_stream_select_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] enable;
    logic       select_ready;
    logic       valid_o [2];
    logic [1:0] data_o  [2];
    logic       busy_o  [2];

    int total = 0;
    int bad   = 0;

    // Model state per instance: index 0 has burst 1, index 1 has burst 3.
    int m_granted [2];
    int m_cur     [2];
    int m_ptr     [2];
    int m_cnt     [2];
    int rot_exp   [6];
    int burst_v   [9];
    int burst_d   [9];

    always #5 clk = ~clk;

    stream_select_arbiter #(.NUM_STREAMS(4), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .req(req), .enable(enable),
        .select_valid(valid_o[0]), .select_ready(select_ready),
        .select_data(data_o[0]), .busy(busy_o[0])
    );

    stream_select_arbiter #(.NUM_STREAMS(4), .MAX_BURST(3)) dut_b3 (
        .clk(clk), .rst_n(rst_n), .req(req), .enable(enable),
        .select_valid(valid_o[1]), .select_ready(select_ready),
        .select_data(data_o[1]), .busy(busy_o[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int findWinner(input logic [3:0] elig, input int start);
        for (int k = 0; k < 4; k++) begin
            if (elig[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_granted[i] = 0;
            m_cur[i]     = 0;
            m_ptr[i]     = 0;
            m_cnt[i]     = 0;
        end
    endtask

    task automatic modelStep();
        int w;
        int mb;
        for (int i = 0; i < 2; i++) begin
            mb = (i == 0) ? 1 : 3;
            if (m_granted[i] == 0) begin
                w = findWinner(req & enable, m_ptr[i]);
                if (w >= 0) begin
                    m_granted[i] = 1;
                    m_cur[i]     = w;
                    m_cnt[i]     = 0;
                end
            end else if (select_ready) begin
                if (m_cnt[i] + 1 < mb && req[m_cur[i]] && enable[m_cur[i]]) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    m_granted[i] = 0;
                    m_ptr[i]     = (m_cur[i] + 1) % 4;
                    m_cnt[i]     = 0;
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_granted[i]));
            checkOutput($sformatf("data%0d", i), 32'(data_o[i]), 32'(m_cur[i]));
            checkOutput($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_granted[i]));
        end
    endtask

    // Inputs change at the falling edge; the model advances at the rising edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] e, input logic rdy);
        req          = r;
        enable       = e;
        select_ready = rdy;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n        = 1'b0;
        req          = 4'h0;
        enable       = 4'hF;
        select_ready = 1'b0;
        modelReset();
        #1;
        compareAll();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compareAll();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        logic [3:0] r;
        logic [3:0] e;
        rot_exp = '{0, 1, 2, 3, 0, 1};
        burst_v = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
        burst_d = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        rst_n        = 1'b0;
        req          = 4'h0;
        enable       = 4'hF;
        select_ready = 1'b0;
        modelReset();

        // Single requester
        resetDut();
        checkOutput("reset_valid", 32'(valid_o[0]), 0);
        checkOutput("reset_data", 32'(data_o[0]), 0);
        repeat (4) applyStimulus(4'h0, 4'hF, 1'b0);
        applyStimulus(4'b0100, 4'hF, 1'b0);
        checkOutput("single_valid", 32'(valid_o[0]), 1);
        checkOutput("single_data", 32'(data_o[0]), 2);
        repeat (2) applyStimulus(4'b0100, 4'hF, 1'b0);
        checkOutput("single_hold", 32'(data_o[0]), 2);
        applyStimulus(4'b0100, 4'hF, 1'b1);
        checkOutput("single_bubble", 32'(valid_o[0]), 0);
        applyStimulus(4'b0100, 4'hF, 1'b0);
        checkOutput("single_regrant", 32'(data_o[0]), 2);

        // Fair rotation on the burst-1 instance
        resetDut();
        for (int k = 0; k < 6; k++) begin
            cycles = 0;
            while (valid_o[0] !== 1'b1 && cycles < 8) begin
                applyStimulus(4'hF, 4'hF, 1'b0);
                cycles++;
            end
            checkOutput("rot_valid", 32'(valid_o[0]), 1);
            repeat (2) applyStimulus(4'hF, 4'hF, 1'b0);
            checkOutput("rot_grant", 32'(data_o[0]), 32'(rot_exp[k]));
            applyStimulus(4'hF, 4'hF, 1'b1);
            checkOutput("rot_bubble", 32'(valid_o[0]), 0);
        end

        // Burst on the burst-3 instance
        resetDut();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(4'b0011, 4'hF, 1'b1);
            checkOutput("burst_valid", 32'(valid_o[1]), 32'(burst_v[k]));
            checkOutput("burst_data", 32'(data_o[1]), 32'(burst_d[k]));
        end

        // Burst early exit
        resetDut();
        applyStimulus(4'b0011, 4'hF, 1'b0);
        checkOutput("early_grant0", 32'(data_o[1]), 0);
        applyStimulus(4'b0010, 4'hF, 1'b1);
        checkOutput("early_bubble", 32'(valid_o[1]), 0);
        applyStimulus(4'b0011, 4'hF, 1'b0);
        checkOutput("early_valid1", 32'(valid_o[1]), 1);
        checkOutput("early_grant1", 32'(data_o[1]), 1);

        // Mask and no revoke
        resetDut();
        applyStimulus(4'b0010, 4'hF, 1'b0);
        checkOutput("mask_grant", 32'(data_o[0]), 1);
        repeat (2) begin
            applyStimulus(4'b1101, 4'b1101, 1'b0);
            checkOutput("norevoke_valid", 32'(valid_o[0]), 1);
            checkOutput("norevoke_data", 32'(data_o[0]), 1);
        end
        applyStimulus(4'b1101, 4'b1101, 1'b1);
        checkOutput("mask_release", 32'(valid_o[0]), 0);
        repeat (12) begin
            applyStimulus(4'hF, 4'b1101, 1'b1);
            checkOutput("mask_skip", 32'(valid_o[0] && data_o[0] == 2'd1), 0);
        end

        // Asynchronous reset in the middle of a grant
        resetDut();
        applyStimulus(4'b1000, 4'hF, 1'b0);
        checkOutput("mid_valid", 32'(valid_o[0]), 1);
        checkOutput("mid_data", 32'(data_o[0]), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(valid_o[0]), 0);
        checkOutput("async_data", 32'(data_o[0]), 0);
        checkOutput("async_busy", 32'(busy_o[0]), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'hF, 4'hF, 1'b0);
        checkOutput("post_reset_grant", 32'(data_o[0]), 0);
        checkOutput("post_reset_valid", 32'(valid_o[0]), 1);

        // Randomized traffic against the model
        resetDut();
        repeat (600) begin
            r = 4'($urandom);
            e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            applyStimulus(r, e, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
